// File: rtl/ddr2_rd_packer.sv
// Packs narrow DDR2 read beats into wide words, queues them, and emits one
// word-count descriptor per completed read request.

module ddr2_rd_packer_fifo #(
    parameter int W          = 8,
    parameter int AW         = 3,
    parameter bit SHOW_AHEAD = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          overflow
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign overflow = push && full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Show-ahead exposes the head combinationally; otherwise q is registered on pop.
    generate
        if (SHOW_AHEAD) begin : g_show_ahead
            assign dout = mem[rd_ptr];
        end else begin : g_registered
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         dout <= '0;
                else if (do_pop) dout <= mem[rd_ptr];
            end
        end
    endgenerate
endmodule

module ddr2_rd_packer #(
    parameter int IN_W       = 32,
    parameter int RATIO      = 4,
    parameter int SIZE_W     = 7,
    parameter int DATA_AW    = 9,
    parameter int Q_AW       = 3,
    parameter int PERMIT_MAX = 6
) (
    input  logic                    ddr2_clk,
    input  logic                    sys_rst,
    input  logic [IN_W-1:0]         local_rdata,
    input  logic                    local_rdata_valid,
    input  logic [SIZE_W-1:0]       rd_ddr2_size,
    input  logic                    rd_ddr2_size_wrreq,
    input  logic                    ddr2um_rdreq,
    output logic [IN_W*RATIO-1:0]   ddr2um_rdata,
    output logic                    ddr2um_empty,
    input  logic                    ddr2um_valid_rdreq,
    output logic [SIZE_W-1:0]       ddr2um_valid_rdata,
    output logic                    ddr2um_valid_empty,
    output logic                    read_permit,
    output logic                    err_orphan,
    output logic                    err_overflow
);
    localparam int OUT_W  = IN_W * RATIO;
    localparam int LANE_W = $clog2(RATIO);

    typedef enum logic {IDLE, PACK} state_t;

    state_t              state, state_n;
    logic [SIZE_W-1:0]   remaining, remaining_n;
    logic [LANE_W-1:0]   lane, lane_n, beat_lane;
    logic [SIZE_W-1:0]   words_q, words_n, words_calc;
    logic [OUT_W-1:0]    acc, acc_n, beat_word;
    logic [OUT_W-1:0]    word_q, word_n;
    logic                word_push_q, word_push_n;
    logic [SIZE_W-1:0]   desc_q, desc_n;
    logic                desc_push_q, desc_push_n;
    logic                size_pop;
    logic                orphan;

    logic [SIZE_W-1:0]   size_head;
    logic [Q_AW:0]       size_count;
    logic [Q_AW:0]       desc_count;
    logic [DATA_AW:0]    data_count;
    logic                size_ovf, data_ovf, desc_ovf;
    logic                size_empty;
    logic [Q_AW+1:0]     entry_sum;

    ddr2_rd_packer_fifo #(.W(SIZE_W), .AW(Q_AW), .SHOW_AHEAD(1'b1)) u_size_fifo (
        .clk      (ddr2_clk),
        .rst      (sys_rst),
        .push     (rd_ddr2_size_wrreq && (rd_ddr2_size != '0)),
        .din      (rd_ddr2_size),
        .pop      (size_pop),
        .dout     (size_head),
        .count    (size_count),
        .overflow (size_ovf)
    );

    ddr2_rd_packer_fifo #(.W(OUT_W), .AW(DATA_AW), .SHOW_AHEAD(1'b0)) u_data_fifo (
        .clk      (ddr2_clk),
        .rst      (sys_rst),
        .push     (word_push_q),
        .din      (word_q),
        .pop      (ddr2um_rdreq),
        .dout     (ddr2um_rdata),
        .count    (data_count),
        .overflow (data_ovf)
    );

    ddr2_rd_packer_fifo #(.W(SIZE_W), .AW(Q_AW), .SHOW_AHEAD(1'b0)) u_desc_fifo (
        .clk      (ddr2_clk),
        .rst      (sys_rst),
        .push     (desc_push_q),
        .din      (desc_q),
        .pop      (ddr2um_valid_rdreq),
        .dout     (ddr2um_valid_rdata),
        .count    (desc_count),
        .overflow (desc_ovf)
    );

    assign size_empty         = (size_count == '0);
    assign ddr2um_empty       = (data_count == '0);
    assign ddr2um_valid_empty = (desc_count == '0);
    assign entry_sum          = (Q_AW+2)'(size_count) + (Q_AW+2)'(desc_count);
    assign read_permit        = (entry_sum <= (Q_AW+2)'(PERMIT_MAX));

    // ceil(head/RATIO) always fits in SIZE_W bits since RATIO >= 2.
    assign words_calc = SIZE_W'(({1'b0, size_head} + (SIZE_W+1)'(RATIO-1)) >> LANE_W);
    assign beat_lane  = (state == IDLE) ? '0 : lane;

    always_comb begin
        beat_word = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (beat_lane == LANE_W'(k))
                beat_word[(RATIO-1-k)*IN_W +: IN_W] = local_rdata;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        lane_n      = lane;
        words_n     = words_q;
        acc_n       = acc;
        word_n      = word_q;
        word_push_n = 1'b0;
        desc_n      = desc_q;
        desc_push_n = 1'b0;
        size_pop    = 1'b0;
        orphan      = 1'b0;
        case (state)
            IDLE: begin
                if (local_rdata_valid) begin
                    if (size_empty) begin
                        orphan = 1'b1;
                    end else begin
                        size_pop    = 1'b1;
                        remaining_n = size_head - SIZE_W'(1);
                        words_n     = words_calc;
                        if (size_head == SIZE_W'(1)) begin
                            word_n      = beat_word;
                            word_push_n = 1'b1;
                            desc_n      = words_calc;
                            desc_push_n = 1'b1;
                            acc_n       = '0;
                            lane_n      = '0;
                        end else begin
                            acc_n   = beat_word;
                            lane_n  = LANE_W'(1);
                            state_n = PACK;
                        end
                    end
                end
            end
            PACK: begin
                if (local_rdata_valid) begin
                    remaining_n = remaining - SIZE_W'(1);
                    if (lane == LANE_W'(RATIO-1) || remaining == SIZE_W'(1)) begin
                        word_n      = beat_word;
                        word_push_n = 1'b1;
                        acc_n       = '0;
                        lane_n      = '0;
                    end else begin
                        acc_n  = beat_word;
                        lane_n = lane + LANE_W'(1);
                    end
                    if (remaining == SIZE_W'(1)) begin
                        desc_n      = words_q;
                        desc_push_n = 1'b1;
                        state_n     = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ddr2_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            remaining   <= '0;
            lane        <= '0;
            words_q     <= '0;
            acc         <= '0;
            word_q      <= '0;
            word_push_q <= 1'b0;
            desc_q      <= '0;
            desc_push_q <= 1'b0;
        end else begin
            state       <= state_n;
            remaining   <= remaining_n;
            lane        <= lane_n;
            words_q     <= words_n;
            acc         <= acc_n;
            word_q      <= word_n;
            word_push_q <= word_push_n;
            desc_q      <= desc_n;
            desc_push_q <= desc_push_n;
        end
    end

    always_ff @(posedge ddr2_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_orphan   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_orphan   <= err_orphan | orphan;
            err_overflow <= err_overflow | size_ovf | data_ovf | desc_ovf;
        end
    end
endmodule

// File: tb/tb_ddr2_rd_packer.sv
// Directed bench for ddr2_rd_packer: packing, padding, orphans, permit throttling,
// data FIFO overflow and asynchronous reset.

module tb_ddr2_rd_packer;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 128;
    localparam int SIZE_W = 7;

    logic               ddr2_clk = 1'b0;
    logic               sys_rst = 1'b0;
    logic [IN_W-1:0]    local_rdata = '0;
    logic               local_rdata_valid = 1'b0;
    logic [SIZE_W-1:0]  rd_ddr2_size = '0;
    logic               rd_ddr2_size_wrreq = 1'b0;
    logic               ddr2um_rdreq = 1'b0;
    logic [OUT_W-1:0]   ddr2um_rdata;
    logic               ddr2um_empty;
    logic               ddr2um_valid_rdreq = 1'b0;
    logic [SIZE_W-1:0]  ddr2um_valid_rdata;
    logic               ddr2um_valid_empty;
    logic               read_permit;
    logic               err_orphan;
    logic               err_overflow;

    int total = 0;
    int bad = 0;
    logic [OUT_W-1:0]  word;
    logic [SIZE_W-1:0] desc;

    ddr2_rd_packer dut (
        .ddr2_clk           (ddr2_clk),
        .sys_rst            (sys_rst),
        .local_rdata        (local_rdata),
        .local_rdata_valid  (local_rdata_valid),
        .rd_ddr2_size       (rd_ddr2_size),
        .rd_ddr2_size_wrreq (rd_ddr2_size_wrreq),
        .ddr2um_rdreq       (ddr2um_rdreq),
        .ddr2um_rdata       (ddr2um_rdata),
        .ddr2um_empty       (ddr2um_empty),
        .ddr2um_valid_rdreq (ddr2um_valid_rdreq),
        .ddr2um_valid_rdata (ddr2um_valid_rdata),
        .ddr2um_valid_empty (ddr2um_valid_empty),
        .read_permit        (read_permit),
        .err_orphan         (err_orphan),
        .err_overflow       (err_overflow)
    );

    always #5 ddr2_clk = ~ddr2_clk;

    task automatic tick();
        @(posedge ddr2_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [OUT_W-1:0] observed,
                               input logic [OUT_W-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_size(input logic [SIZE_W-1:0] s);
        rd_ddr2_size       = s;
        rd_ddr2_size_wrreq = 1'b1;
        tick();
        rd_ddr2_size_wrreq = 1'b0;
    endtask

    // Consecutive beats first, first+1, ... with no idle cycles between them.
    task automatic applyStimulus(input int n, input logic [IN_W-1:0] first);
        for (int i = 0; i < n; i++) begin
            local_rdata       = first + IN_W'(i);
            local_rdata_valid = 1'b1;
            tick();
        end
        local_rdata_valid = 1'b0;
    endtask

    task automatic read_word(output logic [OUT_W-1:0] w);
        ddr2um_rdreq = 1'b1;
        tick();
        ddr2um_rdreq = 1'b0;
        w = ddr2um_rdata;
    endtask

    task automatic read_desc(output logic [SIZE_W-1:0] d);
        ddr2um_valid_rdreq = 1'b1;
        tick();
        ddr2um_valid_rdreq = 1'b0;
        d = ddr2um_valid_rdata;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    initial begin
        #2 sys_rst = 1'b1;
        tick();
        checkOutput("rst_empty", ddr2um_empty, 1);
        checkOutput("rst_valid_empty", ddr2um_valid_empty, 1);
        checkOutput("rst_rdata", ddr2um_rdata, 0);
        checkOutput("rst_valid_rdata", ddr2um_valid_rdata, 0);
        checkOutput("rst_permit", read_permit, 1);
        checkOutput("rst_orphan", err_orphan, 0);
        checkOutput("rst_overflow", err_overflow, 0);
        sys_rst = 1'b0;
        tick();

        // Size 16: four full words
        push_size(7'd16);
        applyStimulus(16, 32'h0);
        tick();
        tick();
        checkOutput("s16_empty", ddr2um_empty, 0);
        checkOutput("s16_valid_empty", ddr2um_valid_empty, 0);
        read_word(word);
        checkOutput("s16_w0", word, 128'h00000000_00000001_00000002_00000003);
        read_word(word);
        checkOutput("s16_w1", word, 128'h00000004_00000005_00000006_00000007);
        read_word(word);
        checkOutput("s16_w2", word, 128'h00000008_00000009_0000000A_0000000B);
        read_word(word);
        checkOutput("s16_w3", word, 128'h0000000C_0000000D_0000000E_0000000F);
        read_desc(desc);
        checkOutput("s16_desc", desc, 4);
        checkOutput("s16_drained", ddr2um_empty, 1);
        checkOutput("s16_desc_drained", ddr2um_valid_empty, 1);

        // Size 6: second word zero-padded
        push_size(7'd6);
        applyStimulus(6, 32'hA);
        tick();
        tick();
        read_word(word);
        checkOutput("s6_w0", word, 128'h0000000A_0000000B_0000000C_0000000D);
        read_word(word);
        checkOutput("s6_w1", word, 128'h0000000E_0000000F_00000000_00000000);
        read_desc(desc);
        checkOutput("s6_desc", desc, 2);

        // Size 1: completes from IDLE; two-cycle latency to empty falling
        push_size(7'd1);
        local_rdata       = 32'h12345678;
        local_rdata_valid = 1'b1;
        tick();
        local_rdata_valid = 1'b0;
        checkOutput("s1_lat1_empty", ddr2um_empty, 1);
        tick();
        checkOutput("s1_lat2_empty", ddr2um_empty, 0);
        checkOutput("s1_lat2_valid_empty", ddr2um_valid_empty, 0);
        read_word(word);
        checkOutput("s1_w0", word, 128'h12345678_00000000_00000000_00000000);
        read_desc(desc);
        checkOutput("s1_desc", desc, 1);

        // Sizes 4 and 5 back-to-back
        push_size(7'd4);
        push_size(7'd5);
        applyStimulus(9, 32'h21);
        tick();
        tick();
        read_word(word);
        checkOutput("b2b_w0", word, 128'h00000021_00000022_00000023_00000024);
        read_word(word);
        checkOutput("b2b_w1", word, 128'h00000025_00000026_00000027_00000028);
        read_word(word);
        checkOutput("b2b_w2", word, 128'h00000029_00000000_00000000_00000000);
        read_desc(desc);
        checkOutput("b2b_desc0", desc, 1);
        read_desc(desc);
        checkOutput("b2b_desc1", desc, 2);

        // Orphan beats, then a normal request
        applyStimulus(3, 32'h91);
        tick();
        tick();
        checkOutput("orph_empty", ddr2um_empty, 1);
        checkOutput("orph_flag", err_orphan, 1);
        push_size(7'd4);
        applyStimulus(4, 32'h31);
        tick();
        tick();
        read_word(word);
        checkOutput("orph_next_w0", word, 128'h00000031_00000032_00000033_00000034);
        read_desc(desc);
        checkOutput("orph_next_desc", desc, 1);
        checkOutput("orph_sticky", err_orphan, 1);
        checkOutput("no_overflow_yet", err_overflow, 0);

        // read_permit throttling
        do_reset();
        checkOutput("permit_rst_orphan", err_orphan, 0);
        for (int i = 0; i < 6; i++) push_size(7'd1);
        checkOutput("permit_at6", read_permit, 1);
        push_size(7'd1);
        checkOutput("permit_at7", read_permit, 0);
        applyStimulus(1, 32'h55);
        tick();
        tick();
        checkOutput("permit_6s_1d", read_permit, 0);
        read_desc(desc);
        checkOutput("permit_desc", desc, 1);
        checkOutput("permit_back", read_permit, 1);

        // Fill the data FIFO with 512 words, popping descriptors as they arrive
        do_reset();
        for (int r = 0; r < 32; r++) begin
            push_size(7'd64);
            applyStimulus(64, IN_W'(r * 64));
            tick();
            tick();
            read_desc(desc);
        end
        checkOutput("fill_desc", desc, 16);
        checkOutput("fill_no_ovf", err_overflow, 0);
        checkOutput("fill_empty", ddr2um_empty, 0);
        push_size(7'd4);
        applyStimulus(4, 32'hAAAA0000);
        tick();
        tick();
        checkOutput("fill_ovf", err_overflow, 1);
        read_word(word);
        checkOutput("fill_w0", word, 128'h00000000_00000001_00000002_00000003);

        // Asynchronous reset in the middle of a request
        push_size(7'd8);
        applyStimulus(2, 32'h77);
        sys_rst = 1'b1;
        #1;
        checkOutput("arst_rdata", ddr2um_rdata, 0);
        checkOutput("arst_empty", ddr2um_empty, 1);
        checkOutput("arst_valid_empty", ddr2um_valid_empty, 1);
        checkOutput("arst_valid_rdata", ddr2um_valid_rdata, 0);
        checkOutput("arst_ovf", err_overflow, 0);
        checkOutput("arst_permit", read_permit, 1);
        tick();
        sys_rst = 1'b0;
        tick();
        push_size(7'd4);
        applyStimulus(4, 32'h41);
        tick();
        tick();
        read_word(word);
        checkOutput("post_rst_w0", word, 128'h00000041_00000042_00000043_00000044);
        read_desc(desc);
        checkOutput("post_rst_desc", desc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr2_rd_packer.md
# ddr2_rd_packer

Parametrised read-return packer between the DDR2 controller local interface and user-side read logic, all on `ddr2_clk`. Narrow `local_rdata` beats are packed MSB-lane-first into wide words, buffered in an internal data FIFO, and each completed read request produces one descriptor holding its wide-word count. Unlike the fixed 32→128 generation, it supports request lengths that are not a multiple of the pack ratio: the last partial word is zero-padded. It also flags orphan beats and overflow, and throttles new DDR2 reads via `read_permit`.

## Interface
- IN_W, 32, local beat width
- RATIO, 4, beats per packed word (power of two, ≥2); OUT_W = IN_W*RATIO
- SIZE_W, 7, request length field width, in beats
- DATA_AW, 9, log2 data FIFO depth
- Q_AW, 3, log2 depth of size FIFO and descriptor FIFO
- PERMIT_MAX, 6, max outstanding entries (size + descriptor) for which `read_permit` stays high

- ddr2_clk  in  1  sole clock, rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- local_rdata  in  IN_W  DDR2 read beat
- local_rdata_valid  in  1  beat valid
- rd_ddr2_size  in  SIZE_W  length of an issued read, in beats
- rd_ddr2_size_wrreq  in  1  push rd_ddr2_size
- ddr2um_rdreq  in  1  pop packed word
- ddr2um_rdata  out  OUT_W  packed word
- ddr2um_empty  out  1  data FIFO empty
- ddr2um_valid_rdreq  in  1  pop descriptor
- ddr2um_valid_rdata  out  SIZE_W  word count of completed request
- ddr2um_valid_empty  out  1  descriptor FIFO empty
- read_permit  out  1  controller may issue another read
- err_orphan  out  1  sticky: beat arrived with no pending size
- err_overflow  out  1  sticky: push attempted into a full FIFO

## Operation
- Size FIFO: synchronous, show-ahead, depth 2^Q_AW. Pushes of size 0 are discarded with no flag. A push while full is dropped and sets err_overflow.
- Packer FSM, states IDLE and PACK:
  - IDLE, beat valid, size FIFO empty: beat dropped; err_orphan set.
  - IDLE, beat valid, size FIFO non-empty:
    - pop head; remaining = head−1; lane = 1; beat goes to lane 0 (bits OUT_W−1..OUT_W−IN_W).
    - latch words = ceil(head/RATIO), computed as (head + RATIO−1) >> log2(RATIO) in SIZE_W+1 bits.
    - if head==1, the word completes immediately and the FSM stays in IDLE; otherwise go to PACK.
  - PACK, beat valid: beat goes to lane `lane`; lane increments and wraps at RATIO; remaining decrements.
    - word completes when lane==RATIO−1 or remaining==1.
    - remaining==1: request done, return to IDLE.
  - No valid beat: all state is held.
- Word complete: all lanes not written in this word are zero; the word is pushed into the data FIFO. The lane register clears for the next word.
- Request done: the descriptor (latched word count) is pushed in the same cycle as the final data word.
- Data or descriptor push while the FIFO is full: entry dropped; err_overflow set. The FSM still advances.
- Read side: ddr2um_rdata and ddr2um_valid_rdata are registered. Data appears the cycle after rdreq; rdreq while empty is ignored and q holds.
- read_permit = (size_count + desc_count) ≤ PERMIT_MAX. Counts are Q_AW+1 bits and the sum is Q_AW+2 bits (no wrap).

## Timing
- Reset values: all FIFOs empty; ddr2um_empty=1, ddr2um_valid_empty=1; rdata outputs 0; err_* = 0; read_permit=1; FSM in IDLE; lane=0.
- Reset asserted mid-request discards the partial word and all FIFO contents.
- Latency from the beat that completes a word to ddr2um_empty falling: 2 cycles (registered push, then registered flag).
- The descriptor becomes visible no earlier than its last data word.
- Full throughput: one beat per cycle indefinitely, including back-to-back requests with no gap between the last beat of one and the first beat of the next.
- Simultaneous push and pop on a FIFO: both are performed and the count is unchanged; a full FIFO still drops the push.
- Size push and size pop in the same cycle: both are performed.
- err_* flags clear only on reset.

## Test plan
- Size 16, 16 consecutive beats 0x0..0xF -> 4 words, first = 0x00000000_00000001_00000002_00000003; one descriptor = 4.
- Size 6, beats A..F -> words {A,B,C,D} and {E,F,0,0}; descriptor = 2. Size 1 -> word {X,0,0,0}, descriptor = 1.
- Sizes 4 and 5 pushed, 9 beats back-to-back with no gap -> words 1, then 2 (last word {b9,0,0,0}); descriptors 1 then 2, in order.
- 3 beats with no size pushed -> no words, err_orphan=1. A following size-4 request packs correctly.
- Push 7 sizes with no reads -> read_permit falls when the count reaches 7. Reading descriptors back down to 6 or fewer total entries -> read_permit rises next cycle.
- Fill the data FIFO (2^DATA_AW words) with no rdreq, then one more word -> word dropped, err_overflow=1. Assert sys_rst mid-request -> all outputs return to reset values in the same cycle.
